// File: rtl/uart_pkg.sv
// Shared definitions for the UART word assembler: FSM state encoding
// and the mapping from byte count to byte lane inside the word.
package uart_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // Lane (0 = least significant byte) that the next received byte occupies,
    // given how many bytes are already held in the partial word.
    function automatic logic [2:0] byte_pos(
        input logic [3:0] cnt,
        input int         bytes,
        input bit         msb_first
    );
        int p;
        if (msb_first) begin
            p = bytes - 1 - int'(cnt);
        end else begin
            p = int'(cnt);
        end
        return 3'(p);
    endfunction

endpackage

// File: rtl/uart_word_assembler_idle_timer.sv
// Idle-cycle counter for the partial-word timeout. Counts enabled cycles
// and flags the cycle in which the TIMEOUT_CYC-th idle cycle is reached.
// TIMEOUT_CYC = 0 disables the timer entirely.
module idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam int LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [TW-1:0] LAST = TW'(LAST_I);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // The count value equals the number of idle cycles already completed,
    // so the current cycle is the last one when cnt_q == TIMEOUT_CYC-1.
    assign expired = (TIMEOUT_CYC != 0) && en && (cnt_q == LAST);

    // Next count: restart on clear, hold once expiry is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_assembler.sv
// Assembles a stream of UART bytes into BYTES-wide words with a
// valid/ready output register, overflow flag, flush and idle timeout.
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int BYTES       = 4,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 byte_i,
    input  logic                       byte_valid_i,
    input  logic                       flush_i,
    output logic [8*BYTES-1:0]         word_o,
    output logic                       word_valid_o,
    input  logic                       word_ready_i,
    output logic [$clog2(BYTES+1)-1:0] byte_cnt_o,
    output logic                       overflow_o,
    output logic                       timeout_o,
    input  logic                       clr_ovf_i
);

    localparam int CW = $clog2(BYTES + 1);
    localparam int WW = 8 * BYTES;
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] buf_q, buf_d;
    logic [WW-1:0] word_q;
    logic          valid_q;
    logic          ovf_q;
    logic          tmo_q;

    logic [CW-1:0] base_cnt;
    logic [2:0]    pos;
    logic [WW-1:0] merged;
    logic          complete;
    logic          load;
    logic          drop;
    logic          tmr_clr;
    logic          tmr_en;
    logic          expired;

    // A flush in the same cycle as a byte makes that byte the first of a new word.
    assign base_cnt = flush_i ? '0 : cnt_q;
    assign pos      = byte_pos(4'(base_cnt), BYTES, MSB_FIRST != 0);
    assign complete = byte_valid_i && (base_cnt == LAST_CNT);

    // Partial word with the incoming byte dropped into its lane.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (byte_valid_i && (pos == 3'(gi))) ? byte_i :
                                       (flush_i ? 8'h00 : buf_q[8*gi +: 8]);
        end
    endgenerate

    // A completed word is dropped only if the output register is full and not draining.
    assign load = complete && (!valid_q || word_ready_i);
    assign drop = complete && valid_q && !word_ready_i;

    // Timer runs only on genuinely idle COLLECT cycles, so a byte or flush wins over expiry.
    assign tmr_clr = byte_valid_i || flush_i || (state_q == ST_IDLE);
    assign tmr_en  = (state_q == ST_COLLECT) && !byte_valid_i && !flush_i;

    idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(expired)
    );

    // Assembly FSM: next state, byte count and partial-word buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (byte_valid_i) begin
            if (complete) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                buf_d   = '0;
            end else begin
                state_d = ST_COLLECT;
                cnt_d   = base_cnt + 1'b1;
                buf_d   = merged;
            end
        end else if (flush_i || expired) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            buf_d   = '0;
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Output word register with valid/ready handshake; a load overrides a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            word_q  <= merged;
            valid_q <= 1'b1;
        end else if (valid_q && word_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overflow flag; a new drop beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

    // One-cycle timeout pulse following the discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= expired;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign byte_cnt_o   = cnt_q;
    assign overflow_o   = ovf_q;
    assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench: two assemblers (MSB-first and LSB-first) share one
// stimulus stream; expected words are queued when issued and checked by
// a monitor at every output handshake.
module tb_uart_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        flush_i;
    logic        word_ready_i;
    logic        clr_ovf_i;

    logic [31:0] word_a, word_b;
    logic        valid_a, valid_b;
    logic [2:0]  cnt_a, cnt_b;
    logic        ovf_a, ovf_b;
    logic        tmo_a, tmo_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    uart_word_assembler #(.BYTES(4), .MSB_FIRST(1), .TIMEOUT_CYC(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .flush_i(flush_i), .word_o(word_a), .word_valid_o(valid_a),
        .word_ready_i(word_ready_i), .byte_cnt_o(cnt_a), .overflow_o(ovf_a),
        .timeout_o(tmo_a), .clr_ovf_i(clr_ovf_i)
    );

    uart_word_assembler #(.BYTES(4), .MSB_FIRST(0), .TIMEOUT_CYC(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .flush_i(flush_i), .word_o(word_b), .word_valid_o(valid_b),
        .word_ready_i(word_ready_i), .byte_cnt_o(cnt_b), .overflow_o(ovf_b),
        .timeout_o(tmo_b), .clr_ovf_i(clr_ovf_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Queue a word the bench expects to be delivered (as MSB-first byte order).
    task automatic expect_word(input logic [31:0] w);
        qa.push_back(w);
        qb.push_back(rev(w));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle byte strobe; byte_i is scrambled afterwards to show it is ignored.
    task automatic send_byte(input logic [7:0] b);
        byte_i       = b;
        byte_valid_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
        byte_i       = 8'($urandom);
    endtask

    // Monitor: every output handshake pops and compares the expected word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && word_ready_i) begin
            if (valid_a) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_unexpected: got %0h required no word", word_a);
                end else begin
                    e = qa.pop_front();
                    chk("a_word", {32'h0, word_a}, {32'h0, e});
                    $display("word msb-first dut: %08h (want %08h)", word_a, e);
                end
            end
            if (valid_b) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected: got %0h required no word", word_b);
                end else begin
                    e = qb.pop_front();
                    chk("b_word", {32'h0, word_b}, {32'h0, e});
                    $display("word lsb-first dut: %08h (want %08h)", word_b, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        flush_i      = 1'b0;
        word_ready_i = 1'b1;
        clr_ovf_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word",  word_a,  0);
        chk("rst_valid", valid_a, 0);
        chk("rst_cnt",   cnt_a,   0);
        chk("rst_ovf",   ovf_a,   0);
        chk("rst_tmo",   tmo_a,   0);
        rst_n = 1'b1;
        tick();

        // Basic word, ready held high.
        expect_word(32'h12345678);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("t1_cnt2", cnt_a, 2);
        send_byte(8'h56);
        send_byte(8'h78);
        chk("t1_valid_lat1", valid_a, 1);
        chk("t1_word_a", word_a, 32'h12345678);
        chk("t1_word_b", word_b, 32'h78563412);
        chk("t1_cnt0", cnt_a, 0);
        tick();
        chk("t1_valid_drop", valid_a, 0);

        // Timeout after two bytes and ten idle cycles.
        send_byte(8'hDE);
        send_byte(8'hAD);
        chk("t2_cnt2", cnt_a, 2);
        repeat (9) tick();
        chk("t2_no_tmo_yet", tmo_a, 0);
        chk("t2_cnt_held", cnt_a, 2);
        tick();
        chk("t2_tmo_pulse", tmo_a, 1);
        chk("t2_tmo_pulse_b", tmo_b, 1);
        chk("t2_cnt_cleared", cnt_a, 0);
        tick();
        chk("t2_tmo_one_cycle", tmo_a, 0);
        expect_word(32'hA1A2A3A4);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        tick();

        // Byte arriving on the would-be timeout cycle wins.
        send_byte(8'h01);
        repeat (9) tick();
        send_byte(8'h02);
        chk("t3_no_tmo", tmo_a, 0);
        chk("t3_cnt2", cnt_a, 2);

        // Flush with a coincident byte restarts at count 1.
        flush_i = 1'b1;
        send_byte(8'h03);
        flush_i = 1'b0;
        chk("t3_flush_cnt1", cnt_a, 1);
        expect_word(32'h03040506);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        tick();

        // Overflow with ready low; clear coinciding with the drop must lose.
        word_ready_i = 1'b0;
        expect_word(32'h11223344);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("t4_valid", valid_a, 1);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        clr_ovf_i = 1'b1;
        send_byte(8'h88);
        clr_ovf_i = 1'b0;
        chk("t4_ovf_set", ovf_a, 1);
        chk("t4_word_held", word_a, 32'h11223344);
        chk("t4_valid_held", valid_a, 1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("t4_ovf_clr", ovf_a, 0);
        word_ready_i = 1'b1;
        tick();
        chk("t4_drained", valid_a, 0);

        // Eight back-to-back bytes with ready held.
        expect_word(32'hCAFEBABE);
        expect_word(32'h12AB34CD);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hBA);
        send_byte(8'hBE);
        send_byte(8'h12);
        send_byte(8'hAB);
        send_byte(8'h34);
        send_byte(8'hCD);
        chk("t5_word2", word_a, 32'h12AB34CD);
        chk("t5_no_ovf", ovf_a, 0);
        tick();

        // Handshake coinciding with word completion: no bubble, no overflow.
        word_ready_i = 1'b0;
        expect_word(32'hDEADBEEF);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        expect_word(32'h10203040);
        word_ready_i = 1'b1;
        send_byte(8'h40);
        chk("t5_b2b_valid", valid_a, 1);
        chk("t5_b2b_word", word_a, 32'h10203040);
        chk("t5_b2b_no_ovf", ovf_a, 0);
        tick();
        chk("t5_b2b_drained", valid_a, 0);

        // Reset mid-word with a pending output word and overflow set.
        word_ready_i = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'h09);
        send_byte(8'h0A);
        send_byte(8'h0B);
        chk("t6_pre_cnt3", cnt_a, 3);
        chk("t6_pre_ovf", ovf_a, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_word",  word_a,  0);
        chk("t6_rst_valid", valid_a, 0);
        chk("t6_rst_cnt",   cnt_a,   0);
        chk("t6_rst_ovf",   ovf_a,   0);
        chk("t6_rst_tmo",   tmo_a,   0);
        tick();
        rst_n        = 1'b1;
        word_ready_i = 1'b1;
        tick();
        expect_word(32'h9ABCDEF0);
        send_byte(8'h9A);
        chk("t6_post_cnt1", cnt_a, 1);
        send_byte(8'hBC);
        send_byte(8'hDE);
        send_byte(8'hF0);
        chk("t6_clean_valid", valid_a, 1);
        chk("t6_clean_word", word_a, 32'h9ABCDEF0);
        repeat (3) tick();

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
